// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the two byte requesters, the FIFO write port and the status
// outputs of fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                    req0_valid;
  logic [2*DATA_WIDTH-1:0] req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [DATA_WIDTH-1:0]   req1_data;
  logic                    req1_ready;
  logic                    full;
  logic                    w_inc;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    busy;
  logic                    grant;

  // Requesters, FIFO flag and observer side.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, full,
    input  req0_ready, req1_ready, w_inc, wr_data, busy, grant
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, full,
    output req0_ready, req1_ready, w_inc, wr_data, busy, grant
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port between a 2-byte ALU source and a 1-byte
// register-file source; one transaction at a time, one byte per cycle.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic [2*DATA_WIDTH-1:0] hold_q;
  logic [1:0]              len_q;
  logic                    last_q;
  logic                    grant_q;
  logic                    accept0;
  logic                    accept1;

  // Round-robin on contention: the requester that did not win last time goes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    accept0 = 1'b0;
    accept1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        accept0 = last_q;
        accept1 = !last_q;
      end else begin
        accept0 = bus.req0_valid;
        accept1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant      = grant_q;

  always_comb begin
    state_d     = state_q;
    bus.w_inc   = 1'b0;
    bus.wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (accept0 || accept1) state_d = SEND_LO;
      end
      SEND_LO: begin
        bus.wr_data = hold_q[DATA_WIDTH-1:0];
        bus.w_inc   = !bus.full;
        if (!bus.full) state_d = (len_q == 2'd2) ? SEND_HI : IDLE;
      end
      SEND_HI: begin
        bus.wr_data = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
        bus.w_inc   = !bus.full;
        if (!bus.full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: hold_q is a single datapath register, not a memory array, so
      // it is cheap to reset and keeps WR_DATA defined straight out of reset.
      state_q <= IDLE;
      hold_q  <= '0;
      len_q   <= 2'd0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      if (accept0) begin
        hold_q  <= bus.req0_data;
        len_q   <= 2'd2;
        last_q  <= 1'b0;
        grant_q <= 1'b0;
      end else if (accept1) begin
        hold_q  <= {{DATA_WIDTH{1'b0}}, bus.req1_data};
        len_q   <= 2'd1;
        last_q  <= 1'b1;
        grant_q <= 1'b1;
      end
    end
  end

  // Handshake invariants the FIFO relies on.
  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(bus.req0_ready && bus.req1_ready));
  a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
    !(bus.w_inc && bus.full));
  a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
    (bus.req0_ready || bus.req1_ready) |-> (state_q == IDLE));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vectors of {valid0, valid1,
// full} with hand-computed {ready0, ready1, w_inc, busy, grant, wr_data}.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {bus.req0_ready, bus.req1_ready, bus.w_inc, bus.busy, bus.grant, bus.wr_data};

  function automatic logic [12:0] pk(input logic r0, input logic r1, input logic w,
                                     input logic b, input logic g, input logic [7:0] d);
    return {r0, r1, w, b, g, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 16'h1234;
    bus.req1_data  = 8'h3C;
    bus.full       = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (obs !== 13'h0)
        $display("FAIL reset[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], 5'b0, 8'h00);
      if (obs !== 13'h0) n_fail++;
      n_checks++;
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_contention();
    logic [2:0]  s [11];
    logic [12:0] e [11];
    s = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000};
    e = '{pk(1,0,0,0,0,8'h00), pk(0,0,1,1,0,8'h34), pk(0,0,1,1,0,8'h12),
          pk(0,1,0,0,0,8'h00), pk(0,0,1,1,1,8'h3C), pk(1,0,0,0,1,8'h00),
          pk(0,0,1,1,0,8'h34), pk(0,0,1,1,0,8'h12), pk(0,1,0,0,0,8'h00),
          pk(0,0,1,1,1,8'h3C), pk(0,0,0,0,1,8'h00)};
    for (int i = 0; i < 11; i++) begin
      {bus.req0_valid, bus.req1_valid, bus.full} = s[i];
      #1;
      if (obs !== e[i]) begin
        $display("FAIL contention[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], e[i][12:8], e[i][7:0]);
        n_fail++;
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_single_req0();
    logic [2:0]  s [4];
    logic [12:0] e [4];
    s = '{3'b100, 3'b000, 3'b000, 3'b000};
    e = '{pk(1,0,0,0,1,8'h00), pk(0,0,1,1,0,8'h5A), pk(0,0,1,1,0,8'hA5), pk(0,0,0,0,0,8'h00)};
    bus.req0_data = 16'hA55A;
    for (int i = 0; i < 4; i++) begin
      {bus.req0_valid, bus.req1_valid, bus.full} = s[i];
      if (i == 1) bus.req0_data = 16'hFFFF;
      #1;
      if (obs !== e[i]) begin
        $display("FAIL single_req0[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], e[i][12:8], e[i][7:0]);
        n_fail++;
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_stall_between_bytes();
    logic [2:0]  s [8];
    logic [12:0] e [8];
    s = '{3'b100, 3'b000, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000};
    e = '{pk(1,0,0,0,0,8'h00), pk(0,0,1,1,0,8'hEF), pk(0,0,0,1,0,8'hBE), pk(0,0,0,1,0,8'hBE),
          pk(0,0,0,1,0,8'hBE), pk(0,0,0,1,0,8'hBE), pk(0,0,1,1,0,8'hBE), pk(0,0,0,0,0,8'h00)};
    bus.req0_data = 16'hBEEF;
    bus.req1_data = 8'h99;
    for (int i = 0; i < 8; i++) begin
      {bus.req0_valid, bus.req1_valid, bus.full} = s[i];
      #1;
      if (obs !== e[i]) begin
        $display("FAIL stall_between_bytes[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], e[i][12:8], e[i][7:0]);
        n_fail++;
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_full_before_first();
    logic [2:0]  s [6];
    logic [12:0] e [6];
    s = '{3'b011, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    e = '{pk(0,1,0,0,0,8'h00), pk(0,0,0,1,1,8'h77), pk(0,0,0,1,1,8'h77),
          pk(0,0,0,1,1,8'h77), pk(0,0,1,1,1,8'h77), pk(0,0,0,0,1,8'h00)};
    bus.req1_data = 8'h77;
    for (int i = 0; i < 6; i++) begin
      {bus.req0_valid, bus.req1_valid, bus.full} = s[i];
      #1;
      if (obs !== e[i]) begin
        $display("FAIL full_before_first[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], e[i][12:8], e[i][7:0]);
        n_fail++;
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  s [9];
    logic [12:0] e [9];
    // Cycles 0-2 lead into SEND_HI; reset is applied after cycle 2.
    s = '{3'b100, 3'b000, 3'b010, 3'b110, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    e = '{pk(1,0,0,0,1,8'h00), pk(0,0,1,1,0,8'hFE), pk(0,0,1,1,0,8'hCA),
          pk(1,0,0,0,0,8'h00), pk(0,0,1,1,0,8'hFE), pk(0,0,1,1,0,8'hCA),
          pk(0,1,0,0,0,8'h00), pk(0,0,1,1,1,8'h5A), pk(0,0,0,0,1,8'h00)};
    bus.req0_data = 16'hCAFE;
    bus.req1_data = 8'h5A;
    for (int i = 0; i < 9; i++) begin
      {bus.req0_valid, bus.req1_valid, bus.full} = s[i];
      #1;
      if (obs !== e[i]) begin
        $display("FAIL reset_mid[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], e[i][12:8], e[i][7:0]);
        n_fail++;
      end
      n_checks++;
      if (i == 2) begin
        rst = 1'b1;
        #1;
        if (obs !== 13'h0) begin
          $display("FAIL reset_mid_assert observed %b_%h expected %b_%h", obs[12:8], obs[7:0], 5'b0, 8'h00);
          n_fail++;
        end
        n_checks++;
        tick();
        if (obs !== 13'h0) begin
          $display("FAIL reset_mid_held observed %b_%h expected %b_%h", obs[12:8], obs[7:0], 5'b0, 8'h00);
          n_fail++;
        end
        n_checks++;
        rst = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_glitch_request();
    logic [2:0]  s [5];
    logic [12:0] e [5];
    s = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b000};
    e = '{pk(1,0,0,0,1,8'h00), pk(0,0,1,1,0,8'h02), pk(0,0,1,1,0,8'h01),
          pk(0,0,0,0,0,8'h00), pk(0,0,0,0,0,8'h00)};
    bus.req0_data = 16'h0102;
    bus.req1_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      {bus.req0_valid, bus.req1_valid, bus.full} = s[i];
      #1;
      if (obs !== e[i]) begin
        $display("FAIL glitch_request[%0d] observed %b_%h expected %b_%h", i, obs[12:8], obs[7:0], e[i][12:8], e[i][7:0]);
        n_fail++;
      end
      n_checks++;
      tick();
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.full       = 1'b0;
    test_reset();
    test_contention();
    test_single_req0();
    test_stall_between_bytes();
    test_full_before_first();
    test_reset_mid();
    test_glitch_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
